// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: operand forwarding, 16-bit ALU, destination select, EX/MEM pipeline registers
//
// Ports
//   clk               in   1   rising-edge clock for the EX/MEM registers
//   rst               in   1   synchronous active-high reset of the EX/MEM registers
//   alu_op            in   4   ALU operation select
//   alu_src           in   1   operand B select: 0 = forwarded reg2, 1 = sign-extended immediate
//   reg1_data         in  16   register-file operand A
//   reg2_data         in  16   register-file operand B
//   immediate         in   6   signed immediate field
//   rd                in   3   R-type destination register
//   rt                in   3   I-type destination register
//   reg_dst           in   2   destination select (rd / rt / link r7 / r0)
//   forward_a         in   2   operand A source (reg / EX-MEM / MEM-WB / reg)
//   forward_b         in   2   operand B source (reg / EX-MEM / MEM-WB / reg)
//   mem_forward_data  in  16   value forwarded from the EX/MEM stage
//   wb_forward_data   in  16   value forwarded from the MEM/WB stage
//   stall             in   1   holds the EX/MEM registers
//   alu_result        out 16   combinational ALU result
//   zero_flag         out  1   combinational, high when alu_result is zero
//   write_reg_addr    out  3   combinational destination register
//   store_data        out 16   combinational forwarded operand B (before the immediate mux)
//   ex_mem_*          out      registered copies of the four combinational outputs

module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  alu_op,
    input  logic        alu_src,
    input  logic [15:0] reg1_data,
    input  logic [15:0] reg2_data,
    input  logic [5:0]  immediate,
    input  logic [2:0]  rd,
    input  logic [2:0]  rt,
    input  logic [1:0]  reg_dst,
    input  logic [1:0]  forward_a,
    input  logic [1:0]  forward_b,
    input  logic [15:0] mem_forward_data,
    input  logic [15:0] wb_forward_data,
    input  logic        stall,
    output logic [15:0] alu_result,
    output logic        zero_flag,
    output logic [2:0]  write_reg_addr,
    output logic [15:0] store_data,
    output logic [15:0] ex_mem_alu_result,
    output logic        ex_mem_zero,
    output logic [2:0]  ex_mem_write_reg,
    output logic [15:0] ex_mem_store_data
);

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_NOR   = 4'd5,
        OP_SLT   = 4'd6,
        OP_SLTU  = 4'd7,
        OP_SLL   = 4'd8,
        OP_SRL   = 4'd9,
        OP_SRA   = 4'd10,
        OP_PASSB = 4'd11
    } alu_op_e;

    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [15:0] imm_ext;
    logic [3:0]  shamt;

    // Pipeline register next-state and state.
    logic [15:0] ex_mem_alu_result_d, ex_mem_alu_result_q;
    logic        ex_mem_zero_d,       ex_mem_zero_q;
    logic [2:0]  ex_mem_write_reg_d,  ex_mem_write_reg_q;
    logic [15:0] ex_mem_store_data_d, ex_mem_store_data_q;

    // Operand A forwarding; code 11 is unused and falls back to the register file.
    always_comb begin
        op_a = reg1_data;
        case (forward_a)
            2'b01:   op_a = mem_forward_data;
            2'b10:   op_a = wb_forward_data;
            default: op_a = reg1_data;
        endcase
    end

    // Forwarded operand B is also the store value, so it is taken before the
    // immediate mux: a store's address uses the immediate while its data still
    // needs forwarding.
    always_comb begin
        store_data = reg2_data;
        case (forward_b)
            2'b01:   store_data = mem_forward_data;
            2'b10:   store_data = wb_forward_data;
            default: store_data = reg2_data;
        endcase
    end

    assign imm_ext = {{10{immediate[5]}}, immediate};
    assign op_b    = alu_src ? imm_ext : store_data;

    // Shifts only honour the low four bits of B, the full range of a 16-bit word.
    assign shamt = op_b[3:0];

    always_comb begin
        alu_result = 16'h0000;
        case (alu_op)
            OP_ADD:   alu_result = op_a + op_b;
            OP_SUB:   alu_result = op_a - op_b;
            OP_AND:   alu_result = op_a & op_b;
            OP_OR:    alu_result = op_a | op_b;
            OP_XOR:   alu_result = op_a ^ op_b;
            OP_NOR:   alu_result = ~(op_a | op_b);
            OP_SLT:   alu_result = {15'd0, ($signed(op_a) < $signed(op_b))};
            OP_SLTU:  alu_result = {15'd0, (op_a < op_b)};
            OP_SLL:   alu_result = op_a << shamt;
            OP_SRL:   alu_result = op_a >> shamt;
            OP_SRA:   alu_result = $signed(op_a) >>> shamt;
            OP_PASSB: alu_result = op_b;
            default:  alu_result = 16'h0000;
        endcase
    end

    assign zero_flag = (alu_result == 16'h0000);

    always_comb begin
        write_reg_addr = rd;
        case (reg_dst)
            2'b00:   write_reg_addr = rd;
            2'b01:   write_reg_addr = rt;
            2'b10:   write_reg_addr = 3'b111;
            default: write_reg_addr = 3'b000;
        endcase
    end

    // EX/MEM registers: capture unless stalled; reset is handled in the flop
    // block so that it overrides a stall.
    always_comb begin
        ex_mem_alu_result_d = ex_mem_alu_result_q;
        ex_mem_zero_d       = ex_mem_zero_q;
        ex_mem_write_reg_d  = ex_mem_write_reg_q;
        ex_mem_store_data_d = ex_mem_store_data_q;
        if (!stall) begin
            ex_mem_alu_result_d = alu_result;
            ex_mem_zero_d       = zero_flag;
            ex_mem_write_reg_d  = write_reg_addr;
            ex_mem_store_data_d = store_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_mem_alu_result_q <= 16'h0000;
            ex_mem_zero_q       <= 1'b0;
            ex_mem_write_reg_q  <= 3'b000;
            ex_mem_store_data_q <= 16'h0000;
        end else begin
            ex_mem_alu_result_q <= ex_mem_alu_result_d;
            ex_mem_zero_q       <= ex_mem_zero_d;
            ex_mem_write_reg_q  <= ex_mem_write_reg_d;
            ex_mem_store_data_q <= ex_mem_store_data_d;
        end
    end

    assign ex_mem_alu_result = ex_mem_alu_result_q;
    assign ex_mem_zero       = ex_mem_zero_q;
    assign ex_mem_write_reg  = ex_mem_write_reg_q;
    assign ex_mem_store_data = ex_mem_store_data_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - scoreboard testbench for ex_stage
module tb_ex_stage;

    logic        clk;
    logic        rst;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic [15:0] reg1_data;
    logic [15:0] reg2_data;
    logic [5:0]  immediate;
    logic [2:0]  rd;
    logic [2:0]  rt;
    logic [1:0]  reg_dst;
    logic [1:0]  forward_a;
    logic [1:0]  forward_b;
    logic [15:0] mem_forward_data;
    logic [15:0] wb_forward_data;
    logic        stall;
    logic [15:0] alu_result;
    logic        zero_flag;
    logic [2:0]  write_reg_addr;
    logic [15:0] store_data;
    logic [15:0] ex_mem_alu_result;
    logic        ex_mem_zero;
    logic [2:0]  ex_mem_write_reg;
    logic [15:0] ex_mem_store_data;

    ex_stage dut (
        .clk               (clk),
        .rst               (rst),
        .alu_op            (alu_op),
        .alu_src           (alu_src),
        .reg1_data         (reg1_data),
        .reg2_data         (reg2_data),
        .immediate         (immediate),
        .rd                (rd),
        .rt                (rt),
        .reg_dst           (reg_dst),
        .forward_a         (forward_a),
        .forward_b         (forward_b),
        .mem_forward_data  (mem_forward_data),
        .wb_forward_data   (wb_forward_data),
        .stall             (stall),
        .alu_result        (alu_result),
        .zero_flag         (zero_flag),
        .write_reg_addr    (write_reg_addr),
        .store_data        (store_data),
        .ex_mem_alu_result (ex_mem_alu_result),
        .ex_mem_zero       (ex_mem_zero),
        .ex_mem_write_reg  (ex_mem_write_reg),
        .ex_mem_store_data (ex_mem_store_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [15:0] res;
        logic        zero;
        logic [2:0]  wr;
        logic [15:0] st;
        logic [15:0] r_res;
        logic        r_zero;
        logic [2:0]  r_wr;
        logic [15:0] r_st;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fails  = 0;
    int vec_idx  = 0;

    // Register model: what the EX/MEM flops should hold after each edge.
    logic [15:0] m_res  = 16'h0;
    logic        m_zero = 1'b0;
    logic [2:0]  m_wr   = 3'b0;
    logic [15:0] m_st   = 16'h0;
    // Inputs/expectations the previous edge sampled.
    logic        p_rst   = 1'b1;
    logic        p_stall = 1'b0;
    logic [15:0] p_res   = 16'h0;
    logic [2:0]  p_wr    = 3'b0;
    logic [15:0] p_st    = 16'h0;

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL v%0d %s: got 0x%04h expected 0x%04h", idx, name, act, exp);
        end
    endtask

    // Monitor: DUT outputs are valid every cycle once a vector is driven; the
    // expected record for the vector is popped at the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("alu_result",        e.idx, alu_result,                e.res);
            chk("zero_flag",         e.idx, {15'd0, zero_flag},        {15'd0, e.zero});
            chk("write_reg_addr",    e.idx, {13'd0, write_reg_addr},   {13'd0, e.wr});
            chk("store_data",        e.idx, store_data,                e.st);
            chk("ex_mem_alu_result", e.idx, ex_mem_alu_result,         e.r_res);
            chk("ex_mem_zero",       e.idx, {15'd0, ex_mem_zero},      {15'd0, e.r_zero});
            chk("ex_mem_write_reg",  e.idx, {13'd0, ex_mem_write_reg}, {13'd0, e.r_wr});
            chk("ex_mem_store_data", e.idx, ex_mem_store_data,         e.r_st);
        end
    end

    task automatic run(
        input logic        v_rst,
        input logic        v_stall,
        input logic [3:0]  v_op,
        input logic        v_src,
        input logic [15:0] v_r1,
        input logic [15:0] v_r2,
        input logic [5:0]  v_imm,
        input logic [1:0]  v_rdst,
        input logic [1:0]  v_fa,
        input logic [1:0]  v_fb,
        input logic [15:0] v_mem,
        input logic [15:0] v_wb,
        input logic [15:0] x_res,
        input logic [2:0]  x_wr,
        input logic [15:0] x_st
    );
        exp_t e;
        @(posedge clk);
        #1;
        if (p_rst) begin
            m_res = 16'h0; m_zero = 1'b0; m_wr = 3'b0; m_st = 16'h0;
        end else if (!p_stall) begin
            m_res = p_res; m_zero = (p_res == 16'h0); m_wr = p_wr; m_st = p_st;
        end
        rst = v_rst; stall = v_stall; alu_op = v_op; alu_src = v_src;
        reg1_data = v_r1; reg2_data = v_r2; immediate = v_imm;
        rd = 3'd2; rt = 3'd3; reg_dst = v_rdst;
        forward_a = v_fa; forward_b = v_fb;
        mem_forward_data = v_mem; wb_forward_data = v_wb;
        e.idx = vec_idx; e.res = x_res; e.zero = (x_res == 16'h0); e.wr = x_wr; e.st = x_st;
        e.r_res = m_res; e.r_zero = m_zero; e.r_wr = m_wr; e.r_st = m_st;
        exp_q.push_back(e);
        p_rst = v_rst; p_stall = v_stall; p_res = x_res; p_wr = x_wr; p_st = x_st;
        vec_idx++;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; alu_op = 4'd0; alu_src = 1'b0;
        reg1_data = 16'h0; reg2_data = 16'h0; immediate = 6'h0;
        rd = 3'd2; rt = 3'd3; reg_dst = 2'b00;
        forward_a = 2'b00; forward_b = 2'b00;
        mem_forward_data = 16'h0; wb_forward_data = 16'h0;

        //   rst   stl   op     src   reg1      reg2      imm     rdst   fa     fb     mem       wb        res       wr    st
        // Reset is active; combinational path must still compute.
        run(1'b1, 1'b0, 4'd0,  1'b0, 16'h0005, 16'h0003, 6'h00,  2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0008, 3'd2, 16'h0003);
        // Basic ALU
        run(1'b0, 1'b0, 4'd0,  1'b0, 16'h0005, 16'h0003, 6'h00,  2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0008, 3'd2, 16'h0003);
        run(1'b0, 1'b0, 4'd1,  1'b0, 16'h0005, 16'h0003, 6'h00,  2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0002, 3'd2, 16'h0003);
        run(1'b0, 1'b0, 4'd1,  1'b0, 16'h0005, 16'h0005, 6'h00,  2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 3'd2, 16'h0005);
        // Forwarding
        run(1'b0, 1'b0, 4'd0,  1'b0, 16'h0005, 16'h0010, 6'h00,  2'b00, 2'b01, 2'b00, 16'h00A0, 16'h0020, 16'h00B0, 3'd2, 16'h0010);
        run(1'b0, 1'b0, 4'd0,  1'b0, 16'h0005, 16'h0010, 6'h00,  2'b00, 2'b01, 2'b10, 16'h00A0, 16'h0020, 16'h00C0, 3'd2, 16'h0020);
        run(1'b0, 1'b0, 4'd0,  1'b0, 16'h0005, 16'h0010, 6'h00,  2'b00, 2'b10, 2'b01, 16'h00A0, 16'h0020, 16'h00C0, 3'd2, 16'h00A0);
        run(1'b0, 1'b0, 4'd0,  1'b0, 16'h0005, 16'h0010, 6'h00,  2'b00, 2'b11, 2'b11, 16'h00A0, 16'h0020, 16'h0015, 3'd2, 16'h0010);
        // Destination select
        run(1'b0, 1'b0, 4'd0,  1'b0, 16'h0005, 16'h0003, 6'h00,  2'b01, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0008, 3'd3, 16'h0003);
        run(1'b0, 1'b0, 4'd0,  1'b0, 16'h0005, 16'h0003, 6'h00,  2'b10, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0008, 3'd7, 16'h0003);
        run(1'b0, 1'b0, 4'd0,  1'b0, 16'h0005, 16'h0003, 6'h00,  2'b11, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0008, 3'd0, 16'h0003);
        // Immediate path; forward_b still drives store_data
        run(1'b0, 1'b0, 4'd0,  1'b1, 16'h0003, 16'h1234, 6'h05,  2'b01, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0008, 3'd3, 16'h1234);
        run(1'b0, 1'b0, 4'd0,  1'b1, 16'h0003, 16'h1234, 6'h3F,  2'b01, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0002, 3'd3, 16'h1234);
        run(1'b0, 1'b0, 4'd0,  1'b1, 16'h0003, 16'h1234, 6'h3F,  2'b01, 2'b00, 2'b01, 16'h7777, 16'h0000, 16'h0002, 3'd3, 16'h7777);
        run(1'b0, 1'b0, 4'd0,  1'b1, 16'h0003, 16'h1234, 6'h20,  2'b01, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'hFFE3, 3'd3, 16'h1234);
        // Compare and shifts
        run(1'b0, 1'b0, 4'd6,  1'b0, 16'hFFFF, 16'h0001, 6'h00,  2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0001, 3'd2, 16'h0001);
        run(1'b0, 1'b0, 4'd7,  1'b0, 16'hFFFF, 16'h0001, 6'h00,  2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 3'd2, 16'h0001);
        run(1'b0, 1'b0, 4'd6,  1'b0, 16'h0001, 16'hFFFF, 6'h00,  2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 3'd2, 16'hFFFF);
        run(1'b0, 1'b0, 4'd7,  1'b0, 16'h0001, 16'hFFFF, 6'h00,  2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0001, 3'd2, 16'hFFFF);
        run(1'b0, 1'b0, 4'd10, 1'b0, 16'h8000, 16'h0004, 6'h00,  2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'hF800, 3'd2, 16'h0004);
        run(1'b0, 1'b0, 4'd9,  1'b0, 16'h8000, 16'h000F, 6'h00,  2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0001, 3'd2, 16'h000F);
        run(1'b0, 1'b0, 4'd8,  1'b0, 16'h0001, 16'h0014, 6'h00,  2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0010, 3'd2, 16'h0014);
        // Logic ops, PASSB, wrap-around and unused codes
        run(1'b0, 1'b0, 4'd2,  1'b0, 16'hFF0F, 16'h0F0F, 6'h00,  2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0F0F, 3'd2, 16'h0F0F);
        run(1'b0, 1'b0, 4'd3,  1'b0, 16'hFF0F, 16'h0F0F, 6'h00,  2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'hFF0F, 3'd2, 16'h0F0F);
        run(1'b0, 1'b0, 4'd4,  1'b0, 16'hFF0F, 16'h0F0F, 6'h00,  2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'hF000, 3'd2, 16'h0F0F);
        run(1'b0, 1'b0, 4'd5,  1'b0, 16'hFF0F, 16'h0F0F, 6'h00,  2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h00F0, 3'd2, 16'h0F0F);
        run(1'b0, 1'b0, 4'd11, 1'b0, 16'h1111, 16'hBEEF, 6'h00,  2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'hBEEF, 3'd2, 16'hBEEF);
        run(1'b0, 1'b0, 4'd0,  1'b0, 16'hFFFF, 16'h0002, 6'h00,  2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0001, 3'd2, 16'h0002);
        run(1'b0, 1'b0, 4'd1,  1'b0, 16'h0000, 16'h0001, 6'h00,  2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'hFFFF, 3'd2, 16'h0001);
        run(1'b0, 1'b0, 4'd12, 1'b0, 16'h1234, 16'h5678, 6'h00,  2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 3'd2, 16'h5678);
        run(1'b0, 1'b0, 4'd15, 1'b0, 16'h1234, 16'h5678, 6'h00,  2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 3'd2, 16'h5678);
        // Capture a known value, then stall with changing inputs
        run(1'b0, 1'b0, 4'd0,  1'b0, 16'h0100, 16'h0023, 6'h00,  2'b10, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0123, 3'd7, 16'h0023);
        run(1'b0, 1'b1, 4'd4,  1'b0, 16'hAAAA, 16'h5555, 6'h00,  2'b01, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'hFFFF, 3'd3, 16'h5555);
        run(1'b0, 1'b1, 4'd1,  1'b0, 16'h0007, 16'h0007, 6'h00,  2'b11, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 3'd0, 16'h0007);
        run(1'b0, 1'b0, 4'd1,  1'b0, 16'h0007, 16'h0007, 6'h00,  2'b11, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 3'd0, 16'h0007);
        run(1'b0, 1'b0, 4'd0,  1'b0, 16'h4000, 16'h0321, 6'h00,  2'b10, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h4321, 3'd7, 16'h0321);
        // Reset asserted mid-operation, together with stall: reset wins at the edge
        run(1'b1, 1'b1, 4'd0,  1'b0, 16'h0001, 16'h0001, 6'h00,  2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0002, 3'd2, 16'h0001);
        run(1'b0, 1'b0, 4'd3,  1'b0, 16'h00F0, 16'h000F, 6'h00,  2'b01, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h00FF, 3'd3, 16'h000F);
        run(1'b0, 1'b0, 4'd0,  1'b0, 16'h0000, 16'h0000, 6'h00,  2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 3'd2, 16'h0000);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL drain: %0d records left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
